// File: rtl/id_filter_pkg.sv
// Shared types and default sizing for the identifier acceptance filter.
package id_filter_pkg;

    localparam int unsigned DEF_ID_WIDTH    = 11;
    localparam int unsigned DEF_NUM_ENTRIES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMPARE = 2'd2,
        REPORT  = 2'd3
    } state_t;

endpackage

// File: rtl/id_filter_entry.sv
// One acceptance-filter table entry: stored id/mask/valid plus its masked compare.
module id_filter_entry
    import id_filter_pkg::*;
#(
    parameter int unsigned ID_WIDTH = DEF_ID_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [ID_WIDTH-1:0] wr_id,
    input  logic [ID_WIDTH-1:0] wr_mask,
    input  logic                wr_en,
    input  logic [ID_WIDTH-1:0] cmp_id,
    output logic                match
);

    logic [ID_WIDTH-1:0] id_q;
    logic [ID_WIDTH-1:0] mask_q;
    logic                en_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q   <= '0;
            mask_q <= '1;
            en_q   <= 1'b0;
        end else if (we) begin
            id_q   <= wr_id;
            mask_q <= wr_mask;
            en_q   <= wr_en;
        end
    end

    // Mask bit 1 means the bit participates; an all-zero mask accepts anything.
    assign match = en_q && (((cmp_id ^ id_q) & mask_q) == '0);

endmodule

// File: rtl/id_filter_ctrl.sv
// Serial identifier capture (3 sample pulses per bit) followed by a prioritised
// acceptance-table lookup with a one-cycle result strobe.
module id_filter_ctrl
    import id_filter_pkg::*;
#(
    parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH,
    parameter int unsigned NUM_ENTRIES = DEF_NUM_ENTRIES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           frameStart,
    input  logic                           abort,
    input  logic                           dIn,
    input  logic                           samplePulse,
    input  logic                           cfgWe,
    input  logic [$clog2(NUM_ENTRIES)-1:0] cfgAddr,
    input  logic [ID_WIDTH-1:0]            cfgId,
    input  logic [ID_WIDTH-1:0]            cfgMask,
    input  logic                           cfgEn,
    output logic                           cfgReady,
    output logic                           busy,
    output logic                           resultValid,
    output logic                           matchHit,
    output logic [$clog2(NUM_ENTRIES)-1:0] matchIdx,
    output logic [ID_WIDTH-1:0]            rxId
);

    localparam int unsigned AW = $clog2(NUM_ENTRIES);
    localparam int unsigned BW = $clog2(ID_WIDTH + 1);

    state_t               state;
    logic [1:0]           pulse_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [ID_WIDTH-1:0]  shift_reg;
    logic [NUM_ENTRIES-1:0] hits;
    logic                 hit_any;
    logic [AW-1:0]        hit_idx;

    assign cfgReady = (state == IDLE);
    assign busy     = (state != IDLE);

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        id_filter_entry #(
            .ID_WIDTH(ID_WIDTH)
        ) u_entry (
            .clk    (clk),
            .reset  (reset),
            .we     (cfgWe && cfgReady && (cfgAddr == AW'(i))),
            .wr_id  (cfgId),
            .wr_mask(cfgMask),
            .wr_en  (cfgEn),
            .cmp_id (shift_reg),
            .match  (hits[i])
        );
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int unsigned i = NUM_ENTRIES; i > 0; i--) begin
            if (hits[i-1]) begin
                hit_any = 1'b1;
                hit_idx = AW'(i - 1);
            end
        end
    end

    // rxId is a separate holding register so an aborted frame cannot disturb
    // the previously reported identifier while shift_reg collects new bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pulse_cnt   <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            resultValid <= 1'b0;
            matchHit    <= 1'b0;
            matchIdx    <= '0;
            rxId        <= '0;
        end else begin
            resultValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (frameStart && enable && !abort) begin
                        state     <= COLLECT;
                        pulse_cnt <= '0;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (samplePulse) begin
                        if (pulse_cnt == 2'd2) begin
                            shift_reg <= {shift_reg[ID_WIDTH-2:0], dIn};
                            pulse_cnt <= '0;
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == BW'(ID_WIDTH - 1)) begin
                                state <= COMPARE;
                            end
                        end else begin
                            pulse_cnt <= pulse_cnt + 2'd1;
                        end
                    end
                end
                COMPARE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        matchHit    <= hit_any;
                        matchIdx    <= hit_idx;
                        rxId        <= shift_reg;
                        resultValid <= 1'b1;
                        state       <= REPORT;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_filter_ctrl.sv
// Directed self-checking bench for id_filter_ctrl (11-bit ids, 4 table entries).
module tb_id_filter_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        frameStart;
    logic        abort;
    logic        dIn;
    logic        samplePulse;
    logic        cfgWe;
    logic [1:0]  cfgAddr;
    logic [10:0] cfgId;
    logic [10:0] cfgMask;
    logic        cfgEn;
    logic        cfgReady;
    logic        busy;
    logic        resultValid;
    logic        matchHit;
    logic [1:0]  matchIdx;
    logic [10:0] rxId;

    int unsigned checks = 0;
    int unsigned errors = 0;

    id_filter_ctrl #(
        .ID_WIDTH   (11),
        .NUM_ENTRIES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frameStart (frameStart),
        .abort      (abort),
        .dIn        (dIn),
        .samplePulse(samplePulse),
        .cfgWe      (cfgWe),
        .cfgAddr    (cfgAddr),
        .cfgId      (cfgId),
        .cfgMask    (cfgMask),
        .cfgEn      (cfgEn),
        .cfgReady   (cfgReady),
        .busy       (busy),
        .resultValid(resultValid),
        .matchHit   (matchHit),
        .matchIdx   (matchIdx),
        .rxId       (rxId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input logic [1:0] addr, input logic [10:0] id,
                               input logic [10:0] mask, input logic en);
        cfgWe = 1'b1; cfgAddr = addr; cfgId = id; cfgMask = mask; cfgEn = en;
        step();
        cfgWe = 1'b0;
    endtask

    task automatic start_frame();
        frameStart = 1'b1;
        step();
        frameStart = 1'b0;
    endtask

    // Sends the low n bits of v MSB first, three pulses per bit, idle cycle between pulses.
    task automatic send_bits(input logic [15:0] v, input int unsigned n);
        for (int unsigned b = n; b > 0; b--) begin
            for (int unsigned p = 0; p < 3; p++) begin
                dIn = v[b-1];
                samplePulse = 1'b1;
                step();
                samplePulse = 1'b0;
                if (!(b == 1 && p == 2)) step();
            end
        end
    endtask

    // Called right after the final capturing pulse's edge.
    task automatic finish_frame(input string tag, input logic hit, input logic [1:0] idx,
                                input logic [10:0] id);
        check({tag, "_rv_early"}, 32'(resultValid), 32'd0);
        step();
        check({tag, "_rv"}, 32'(resultValid), 32'd1);
        check({tag, "_hit"}, 32'(matchHit), 32'(hit));
        check({tag, "_idx"}, 32'(matchIdx), 32'(idx));
        check({tag, "_rxid"}, 32'(rxId), 32'(id));
        step();
        check({tag, "_rv_end"}, 32'(resultValid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic seen_rv;
        reset = 1'b1; enable = 1'b1; frameStart = 1'b0; abort = 1'b0; dIn = 1'b0;
        samplePulse = 1'b0; cfgWe = 1'b0; cfgAddr = '0; cfgId = '0; cfgMask = '0; cfgEn = 1'b0;
        step();
        step();
        check("rst_cfgReady", 32'(cfgReady), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rv", 32'(resultValid), 32'd0);
        check("rst_hit", 32'(matchHit), 32'd0);
        check("rst_idx", 32'(matchIdx), 32'd0);
        check("rst_rxid", 32'(rxId), 32'd0);
        reset = 1'b0;
        step();

        // Exact match on entry 0
        write_entry(2'd0, 11'h123, 11'h7FF, 1'b1);
        start_frame();
        check("collect_busy", 32'(busy), 32'd1);
        send_bits(16'h0123, 11);
        finish_frame("f123", 1'b1, 2'd0, 11'h123);

        // Entries 1 and 2 both match 0x0A5; lowest wins, then entry 2 after disabling 1
        write_entry(2'd1, 11'h0A5, 11'h7FF, 1'b1);
        write_entry(2'd2, 11'h0FF, 11'h700, 1'b1);
        start_frame();
        send_bits(16'h00A5, 11);
        finish_frame("prio1", 1'b1, 2'd1, 11'h0A5);
        write_entry(2'd1, 11'h0A5, 11'h7FF, 1'b0);
        start_frame();
        send_bits(16'h00A5, 11);
        finish_frame("prio2", 1'b1, 2'd2, 11'h0A5);

        // Abort after five bits of 0x7FF: prior results held, no strobe
        start_frame();
        send_bits(16'h001F, 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rv", 32'(resultValid), 32'd0);
        check("abort_hit", 32'(matchHit), 32'd1);
        check("abort_idx", 32'(matchIdx), 32'd2);
        check("abort_rxid", 32'(rxId), 32'h0A5);
        seen_rv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            samplePulse = 1'b1;
            step();
            seen_rv = seen_rv | resultValid;
        end
        samplePulse = 1'b0;
        check("abort_no_rv", 32'(seen_rv), 32'd0);
        start_frame();
        send_bits(16'h00A5, 11);
        finish_frame("post_abort", 1'b1, 2'd2, 11'h0A5);

        // No enabled entry
        write_entry(2'd0, 11'h123, 11'h7FF, 1'b0);
        write_entry(2'd2, 11'h0FF, 11'h700, 1'b0);
        start_frame();
        send_bits(16'h07FF, 11);
        finish_frame("nohit", 1'b0, 2'd0, 11'h7FF);

        // Table write during COLLECT is dropped
        start_frame();
        send_bits(16'h0000, 3);
        check("collect_cfgReady", 32'(cfgReady), 32'd0);
        write_entry(2'd3, 11'h0A5, 11'h7FF, 1'b1);
        send_bits(16'h00A5, 8);
        finish_frame("busy_wr", 1'b0, 2'd0, 11'h0A5);

        // Write coinciding with frameStart is applied; zero mask accepts any id
        cfgWe = 1'b1; cfgAddr = 2'd3; cfgId = 11'h000; cfgMask = 11'h000; cfgEn = 1'b1;
        frameStart = 1'b1;
        step();
        cfgWe = 1'b0; frameStart = 1'b0;
        send_bits(16'h03C4, 11);
        finish_frame("start_wr", 1'b1, 2'd3, 11'h3C4);

        // frameStart ignored while disabled
        enable = 1'b0;
        start_frame();
        check("disabled_busy", 32'(busy), 32'd0);
        enable = 1'b1;

        // Asynchronous reset mid-COLLECT, then table must be back to defaults
        start_frame();
        send_bits(16'h000A, 4);
        reset = 1'b1;
        #2;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cfgReady", 32'(cfgReady), 32'd1);
        check("arst_rv", 32'(resultValid), 32'd0);
        check("arst_hit", 32'(matchHit), 32'd0);
        check("arst_idx", 32'(matchIdx), 32'd0);
        check("arst_rxid", 32'(rxId), 32'd0);
        step();
        reset = 1'b0;
        step();
        start_frame();
        send_bits(16'h03C4, 11);
        finish_frame("post_rst", 1'b0, 2'd0, 11'h3C4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_filter_ctrl.md
ID_FILTER_CTRL -- requirements
Module: id_filter_ctrl

Interface
REQ-001 Parameter ID_WIDTH, 11, received identifier length in bits.
REQ-002 Parameter NUM_ENTRIES, 4, acceptance-filter table depth (power of two, 2..16).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  filtering allowed; frameStart ignored while low.
REQ-006 frameStart  in  1  one-cycle pulse marking the first ID bit period.
REQ-007 abort  in  1  frame error; cancels the frame in progress.
REQ-008 dIn  in  1  serial bus data, MSB of ID first.
REQ-009 samplePulse  in  1  sample strobe, three pulses per bit.
REQ-010 cfgWe  in  1  table write strobe.
REQ-011 cfgAddr  in  log2(NUM_ENTRIES)  table entry index.
REQ-012 cfgId  in  ID_WIDTH  acceptance ID.
REQ-013 cfgMask  in  ID_WIDTH  compare mask; 1 = bit compared.
REQ-014 cfgEn  in  1  entry valid.
REQ-015 cfgReady  out  1  table writable (state IDLE).
REQ-016 busy  out  1  frame in progress (any state except IDLE).
REQ-017 resultValid  out  1  one-cycle result strobe.
REQ-018 matchHit  out  1  at least one enabled entry matched.
REQ-019 matchIdx  out  log2(NUM_ENTRIES)  lowest matching entry index.
REQ-020 rxId  out  ID_WIDTH  captured identifier.

Function
REQ-021 States IDLE, COLLECT, COMPARE, REPORT.
REQ-022 IDLE: frameStart & enable -> COLLECT; clears bit counter, pulse counter (0..2) and rxId shift register.
REQ-023 COLLECT: each samplePulse increments pulse counter; on the third pulse (counter==2) dIn shifts into rxId LSB in that cycle, bit counter increments, pulse counter returns to 0.
REQ-024 COLLECT -> COMPARE on the cycle capturing bit ID_WIDTH; samplePulse in COMPARE/REPORT is ignored.
REQ-025 COMPARE: entry i matches when cfgEn[i] and ((rxId XOR id[i]) AND mask[i]) == 0; matchHit/matchIdx registered (lowest index wins; idx 0 when no hit); -> REPORT.
REQ-026 REPORT: resultValid high exactly one cycle; -> IDLE.
REQ-027 Latency: resultValid asserts 2 cycles after the final capturing samplePulse cycle.
REQ-028 matchHit, matchIdx, rxId hold until the next frame's COMPARE.
REQ-029 abort in COLLECT/COMPARE/REPORT -> IDLE next cycle, no resultValid, results unchanged; abort beats samplePulse and frameStart.
REQ-030 frameStart outside IDLE ignored.
REQ-031 cfgWe writes entry cfgAddr only when cfgReady; otherwise dropped, no side effect.
REQ-032 cfgWe and frameStart in the same IDLE cycle: write applied; frame uses updated table.
REQ-033 Mask all zeros on an enabled entry matches any ID.

Reset
REQ-034 Reset -> IDLE; counters, rxId 0; busy, resultValid, matchHit, matchIdx 0; cfgReady 1.
REQ-035 Table after reset: id 0, mask all ones, cfgEn 0 for every entry.
REQ-036 Reset mid-frame discards the frame immediately; no resultValid.

Structure
REQ-037 Package id_filter_pkg holds the state enum and ID_WIDTH/NUM_ENTRIES defaults.
REQ-038 One sub-module id_filter_entry: per-entry storage and masked compare, instantiated NUM_ENTRIES times; priority encode in top.

Verification
REQ-039 Entry0 id 0x123 mask 0x7FF en; send 0x123 (33 pulses) -> resultValid 2 cycles after pulse 33, matchHit 1, matchIdx 0, rxId 0x123.
REQ-040 Entries 1 and 2 match 0x0A5 (entry2 mask 0x700) -> matchIdx 1; disable entry1 -> matchIdx 2.
REQ-041 No enabled entry, send 0x7FF -> matchHit 0, matchIdx 0, resultValid 1 pulse.
REQ-042 abort after bit 5 -> busy 0 next cycle, no resultValid, prior results held; next frame completes normally.
REQ-043 cfgWe during COLLECT to entry3 -> table unchanged; cfgWe with frameStart in IDLE -> new entry used.
REQ-044 Reset asserted mid-COLLECT -> all outputs at reset values asynchronously, cfgReady 1.
